// File: rtl/ulpi_rx_capture.sv
// ULPI receive front-end: tracks bus turnaround, separates RX CMD bytes from packet bytes and pushes packet bytes to the FIFO.
// Optional feature macro USB_PKT_LEN_TRAILER_EN appends one packet-length byte after each packet.
module ulpi_rx_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk_ext,
    input  logic             rstn,
    input  logic [7:0]       DATA,
    input  logic             DIR,
    input  logic             NXT,
    output logic             STP,
    input  logic             FIFO_full,
    output logic [7:0]       FIFO_in,
    output logic             FIFO_save,
    input  logic             clr_ovf,
    output logic             rx_active,
    output logic [1:0]       linestate,
    output logic [7:0]       rx_cmd,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_IN  = 2'd1,
        RX       = 2'd2,
        TURN_OUT = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       cyc_start, cyc_cmd, cyc_byte, cyc_turn_out;
    logic       active_nxt, pkt_start, pkt_end;
    logic       data_push, data_drop, trl_push, trl_drop;
    logic [7:0] len;

    always_ff @(posedge clk_ext or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // state_nxt is the classification of the cycle being sampled at this edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (DIR) state_nxt = TURN_IN;
            TURN_IN:  state_nxt = DIR ? RX : TURN_OUT;
            RX:       if (!DIR) state_nxt = TURN_OUT;
            TURN_OUT: state_nxt = DIR ? TURN_IN : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cyc_start    = 1'b0;
        cyc_cmd      = 1'b0;
        cyc_byte     = 1'b0;
        cyc_turn_out = 1'b0;
        case (state_nxt)
            TURN_IN:  cyc_start = NXT;
            RX: begin
                cyc_cmd  = ~NXT;
                cyc_byte = NXT;
            end
            TURN_OUT: cyc_turn_out = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        active_nxt = rx_active;
        if (cyc_start)         active_nxt = 1'b1;
        else if (cyc_cmd)      active_nxt = DATA[4];
        else if (cyc_turn_out) active_nxt = 1'b0;
    end

    assign pkt_start = ~rx_active & active_nxt;
    assign pkt_end   = rx_active & ~active_nxt;
    assign data_push = cyc_byte & ~FIFO_full;
    assign data_drop = cyc_byte & FIFO_full;

`ifdef USB_PKT_LEN_TRAILER_EN
    // end-of-packet cycle is never a data cycle, so the trailer has the FIFO to itself
    assign trl_push = pkt_end & ~FIFO_full;
    assign trl_drop = pkt_end & FIFO_full;
`else
    assign trl_push = 1'b0;
    assign trl_drop = 1'b0;
`endif

    always_ff @(posedge clk_ext or negedge rstn) begin
        if (!rstn) begin
            STP       <= 1'b1;
            rx_active <= 1'b0;
            rx_cmd    <= 8'h00;
            pkt_cnt   <= '0;
            overflow  <= 1'b0;
            len       <= 8'h00;
        end else begin
            if (!DIR)    STP <= 1'b0;
            rx_active <= active_nxt;
            if (cyc_cmd) rx_cmd <= DATA;
            if (pkt_end) pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (data_drop || trl_drop) overflow <= 1'b1;
            else if (clr_ovf)          overflow <= 1'b0;
            // dropped bytes still count toward the packet length
            if (pkt_start)                     len <= 8'h00;
            else if (cyc_byte && len != 8'hFF) len <= len + 8'd1;
        end
    end

    always_ff @(posedge clk_ext or negedge rstn) begin
        if (!rstn) begin
            FIFO_in   <= 8'h00;
            FIFO_save <= 1'b0;
        end else begin
            FIFO_save <= data_push | trl_push;
            if (data_push)     FIFO_in <= DATA;
            else if (trl_push) FIFO_in <= len;
        end
    end

    assign linestate = rx_cmd[1:0];

endmodule

// File: tb/tb_ulpi_rx_capture.sv
// Self-checking bench for ulpi_rx_capture: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ulpi_rx_capture;

    localparam int CNT_W = 16;

    logic             clk_ext = 1'b0;
    logic             rstn;
    logic [7:0]       DATA;
    logic             DIR, NXT, FIFO_full, clr_ovf;
    logic             STP, FIFO_save, rx_active, overflow;
    logic [7:0]       FIFO_in, rx_cmd;
    logic [1:0]       linestate;
    logic [CNT_W-1:0] pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] cap_q[$];
    int         cap_t[$];

    // reference model state: bus owner in the previous sampled cycle, packet flags and counters
    logic        m_prev_dir, m_active, m_ovf, m_stp, m_save;
    logic [7:0]  m_rx_cmd, m_fifo_in;
    int          m_len;
    logic [15:0] m_cnt;

    localparam logic [37:0] RESET_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0};

    ulpi_rx_capture #(.CNT_W(CNT_W)) dut (
        .clk_ext(clk_ext), .rstn(rstn), .DATA(DATA), .DIR(DIR), .NXT(NXT), .STP(STP),
        .FIFO_full(FIFO_full), .FIFO_in(FIFO_in), .FIFO_save(FIFO_save), .clr_ovf(clr_ovf),
        .rx_active(rx_active), .linestate(linestate), .rx_cmd(rx_cmd), .pkt_cnt(pkt_cnt),
        .overflow(overflow)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic model_reset();
        m_prev_dir = 1'b0; m_active = 1'b0; m_ovf = 1'b0; m_stp = 1'b1; m_save = 1'b0;
        m_rx_cmd = 8'h00; m_fifo_in = 8'h00; m_len = 0; m_cnt = 16'h0;
    endtask

    task automatic model_step(input logic d, input logic n, input logic [7:0] dat,
                              input logic full, input logic clr);
        logic was, set_ovf;
        was = m_active; set_ovf = 1'b0; m_save = 1'b0;
        if (!m_prev_dir && d && n)      m_active = 1'b1;
        else if (m_prev_dir && d && !n) begin m_rx_cmd = dat; m_active = dat[4]; end
        else if (m_prev_dir && !d)      m_active = 1'b0;
        if (!was && m_active) m_len = 0;
        if (m_prev_dir && d && n) begin
            if (full) set_ovf = 1'b1;
            else begin m_save = 1'b1; m_fifo_in = dat; end
            if (m_len < 255) m_len++;
        end
        if (was && !m_active) begin
            m_cnt++;
`ifdef USB_PKT_LEN_TRAILER_EN
            if (full) set_ovf = 1'b1;
            else begin m_save = 1'b1; m_fifo_in = 8'(m_len); end
`endif
        end
        if (set_ovf)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (!d) m_stp = 1'b0;
        m_prev_dir = d;
    endtask

    task automatic step(input logic d, input logic n, input logic [7:0] dat,
                        input logic full = 1'b0, input logic clr = 1'b0);
        DIR = d; NXT = n; DATA = dat; FIFO_full = full; clr_ovf = clr;
        @(posedge clk_ext); #1;
        model_step(d, n, dat, full, clr);
        cyc++;
        if (FIFO_save) begin cap_q.push_back(FIFO_in); cap_t.push_back(cyc); end
    endtask

    task automatic test_reset();
        rstn = 1'b0; DIR = 1'b0; NXT = 1'b0; DATA = 8'h00; FIFO_full = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_ext);
        n_checks++;
        if ({STP, FIFO_save, FIFO_in, rx_active, rx_cmd, linestate, pkt_cnt, overflow} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h",
                     {STP, FIFO_save, FIFO_in, rx_active, rx_cmd, linestate, pkt_cnt, overflow}, RESET_VEC);
        end
        rstn = 1'b1;
        #1;
        n_checks++;
        if (STP !== 1'b1) begin n_fail++; $display("FAIL stp_before_edge: got %b expected 1", STP); end
        step(1'b0, 1'b0, 8'h5A);
        n_checks++;
        if (STP !== 1'b0) begin n_fail++; $display("FAIL stp_after_dir0: got %b expected 0", STP); end
        n_checks++;
        if ({FIFO_save, rx_active, pkt_cnt, overflow} !== 19'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got save=%b act=%b cnt=%0d ovf=%b expected all 0",
                     FIFO_save, rx_active, pkt_cnt, overflow);
        end
    endtask

    task automatic test_packet();
        logic [7:0] exp_q[$];
        int c3_cyc;
        exp_q = '{8'hC3, 8'hA5, 8'h0F};
`ifdef USB_PKT_LEN_TRAILER_EN
        exp_q.push_back(8'h03);
`endif
        cap_q.delete(); cap_t.delete();
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h11);
        n_checks++;
        if (rx_active !== 1'b1) begin n_fail++; $display("FAIL pkt_active: got %b expected 1", rx_active); end
        step(1'b1, 1'b1, 8'hC3); c3_cyc = cyc;
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h0F);
        step(1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h99);
        step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL pkt_push_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL pkt_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (cap_t[0] != c3_cyc || cap_t[2] != c3_cyc + 2) begin
                n_fail++; $display("FAIL pkt_timing: got cycles %0d,%0d expected %0d,%0d",
                                   cap_t[0], cap_t[2], c3_cyc, c3_cyc + 2);
            end
        end
        n_checks++;
        if ({rx_active, pkt_cnt, linestate} !== {1'b0, 16'd1, 2'b01}) begin
            n_fail++; $display("FAIL pkt_status: got act=%b cnt=%0d ls=%b expected act=0 cnt=1 ls=01",
                               rx_active, pkt_cnt, linestate);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [15:0] cnt0;
        cnt0 = pkt_cnt;
        exp_q = '{8'hC3, 8'h0F};
`ifdef USB_PKT_LEN_TRAILER_EN
        exp_q.push_back(8'h03);
`endif
        cap_q.delete(); cap_t.delete();
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        step(1'b1, 1'b1, 8'h0F);
        step(1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_push_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || pkt_cnt !== cnt0 + 16'd1) begin
            n_fail++; $display("FAIL ovf_sticky: got ovf=%b cnt=%0d expected ovf=1 cnt=%0d",
                               overflow, pkt_cnt, cnt0 + 16'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        // drop and clear in the same cycle: the drop must win
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h42, 1'b1, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        logic [7:0] exp_q[$];
        logic [15:0] cnt0;
        cnt0 = pkt_cnt;
        exp_q = '{8'h3C, 8'hE1};
`ifdef USB_PKT_LEN_TRAILER_EN
        exp_q.push_back(8'h02);
`endif
        cap_q.delete(); cap_t.delete();
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b1, 1'b1, 8'hE1);
        step(1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (cap_q != exp_q) begin
            n_fail++; $display("FAIL abort_pushes: got %p expected %p", cap_q, exp_q);
        end
        n_checks++;
        if ({rx_active, pkt_cnt} !== {1'b0, cnt0 + 16'd1}) begin
            n_fail++; $display("FAIL abort_count: got act=%b cnt=%0d expected act=0 cnt=%0d",
                               rx_active, pkt_cnt, cnt0 + 16'd1);
        end
    endtask

    task automatic test_saturation();
        cap_q.delete(); cap_t.delete();
        step(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'(i));
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
`ifdef USB_PKT_LEN_TRAILER_EN
        n_checks++;
        if (cap_q.size() != 301 || cap_q[cap_q.size()-1] !== 8'hFF) begin
            n_fail++; $display("FAIL sat_trailer: got n=%0d last=%h expected n=301 last=ff",
                               cap_q.size(), cap_q.size() ? cap_q[cap_q.size()-1] : 8'h00);
        end
`else
        n_checks++;
        if (cap_q.size() != 300) begin
            n_fail++; $display("FAIL sat_count: got %0d expected 300", cap_q.size());
        end
`endif
    endtask

    task automatic test_random();
        logic d;
        d = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 2) d = ~d;
            step(d, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0);
            n_checks++;
            if (FIFO_save !== m_save || (m_save && FIFO_in !== m_fifo_in)) begin
                n_fail++; $display("FAIL rnd_fifo cyc %0d: got save=%b in=%h expected save=%b in=%h",
                                   cyc, FIFO_save, FIFO_in, m_save, m_fifo_in);
            end
            n_checks++;
            if ({rx_active, rx_cmd, linestate} !== {m_active, m_rx_cmd, m_rx_cmd[1:0]}) begin
                n_fail++; $display("FAIL rnd_cmd cyc %0d: got act=%b cmd=%h ls=%b expected act=%b cmd=%h",
                                   cyc, rx_active, rx_cmd, linestate, m_active, m_rx_cmd);
            end
            n_checks++;
            if ({pkt_cnt, overflow, STP} !== {m_cnt, m_ovf, m_stp}) begin
                n_fail++; $display("FAIL rnd_status cyc %0d: got cnt=%0d ovf=%b stp=%b expected cnt=%0d ovf=%b stp=%b",
                                   cyc, pkt_cnt, overflow, STP, m_cnt, m_ovf, m_stp);
            end
        end
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_packet();
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h12);
        step(1'b1, 1'b1, 8'h34);
        #2;
        rstn = 1'b0; DIR = 1'b0; NXT = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({STP, FIFO_save, FIFO_in, rx_active, rx_cmd, linestate, pkt_cnt, overflow} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h",
                     {STP, FIFO_save, FIFO_in, rx_active, rx_cmd, linestate, pkt_cnt, overflow}, RESET_VEC);
        end
        repeat (2) @(negedge clk_ext);
        rstn = 1'b1;
        cap_q.delete(); cap_t.delete();
        repeat (5) step(1'b0, 1'b0, 8'hAB);
        n_checks++;
        if (cap_q.size() != 0 || pkt_cnt !== 16'd0 || rx_active !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_quiet: got pushes=%0d cnt=%0d act=%b expected 0 0 0",
                               cap_q.size(), pkt_cnt, rx_active);
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_overflow();
        test_abort();
        test_saturation();
        test_random();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
